// File: rtl/aq32_bus_pkg.sv
// Shared bus constants and arbiter state encoding for the aq32 SRAM path.
package aq32_bus_pkg;

    localparam int unsigned SRAM_ADDR_W = 17;
    localparam int unsigned BUS_DATA_W  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    // One-hot owner vector for a given arbiter state.
    function automatic logic [1:0] grant_of(input arb_state_e st);
        case (st)
            ARB_GNT0: grant_of = 2'b01;
            ARB_GNT1: grant_of = 2'b10;
            default:  grant_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of sram_ctrl: fixed m0 priority with an m1 starvation guard,
// or alternating priority when SRAM_ARB_ROUND_ROBIN_EN is defined.
module sram_arbiter
    import aq32_bus_pkg::*;
#(
    parameter int unsigned ADDR_W       = SRAM_ADDR_W,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [BUS_DATA_W-1:0] m0_wrdata,
    input  logic [3:0]            m0_bytesel,
    input  logic                  m0_wren,
    input  logic                  m0_strobe,
    output logic                  m0_wait,
    output logic [BUS_DATA_W-1:0] m0_rddata,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [BUS_DATA_W-1:0] m1_wrdata,
    input  logic [3:0]            m1_bytesel,
    input  logic                  m1_wren,
    input  logic                  m1_strobe,
    output logic                  m1_wait,
    output logic [BUS_DATA_W-1:0] m1_rddata,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [BUS_DATA_W-1:0] s_wrdata,
    output logic [3:0]            s_bytesel,
    output logic                  s_wren,
    output logic                  s_strobe,
    input  logic                  s_wait,
    input  logic [BUS_DATA_W-1:0] s_rddata,
    output logic [1:0]            grant
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       m1_first;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // 1 = m1 owned the last completed transfer, so m0 wins the next tie.
    logic last_owner;

    assign m1_first = ~last_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= 1'b1;
        end else if (state_q == ARB_GNT0 && m0_strobe && !s_wait) begin
            last_owner <= 1'b0;
        end else if (state_q == ARB_GNT1 && m1_strobe && !s_wait) begin
            last_owner <= 1'b1;
        end
    end
`else
    logic [7:0] starve_cnt;

    assign m1_first = (32'(starve_cnt) >= STARVE_LIMIT);

    // Counts cycles m1 has been kept waiting; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (!m1_strobe || state_d == ARB_GNT1) begin
            starve_cnt <= 8'd0;
        end else if (state_q != ARB_GNT1 && starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant   <= 2'b00;
        end else begin
            state_q <= state_d;
            grant   <= grant_of(state_d);
        end
    end

    // Next-state decode and the combinational command/response mux.
    always_comb begin
        state_d   = state_q;
        s_addr    = '0;
        s_wrdata  = '0;
        s_bytesel = 4'b0000;
        s_wren    = 1'b0;
        s_strobe  = 1'b0;
        m0_wait   = 1'b1;
        m1_wait   = 1'b1;
        m0_rddata = '0;
        m1_rddata = '0;

        case (state_q)
            ARB_IDLE: begin
                if (m1_strobe && (!m0_strobe || m1_first)) begin
                    state_d = ARB_GNT1;
                end else if (m0_strobe) begin
                    state_d = ARB_GNT0;
                end
            end
            ARB_GNT0: begin
                s_addr    = m0_addr;
                s_wrdata  = m0_wrdata;
                s_bytesel = m0_bytesel;
                s_wren    = m0_wren;
                s_strobe  = m0_strobe;
                m0_wait   = s_wait;
                m0_rddata = s_rddata;
                // Completion or abort both release the port for a fresh arbitration.
                if (!m0_strobe || !s_wait) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                s_addr    = m1_addr;
                s_wrdata  = m1_wrdata;
                s_bytesel = m1_bytesel;
                s_wren    = m1_wren;
                s_strobe  = m1_strobe;
                m1_wait   = s_wait;
                m1_rddata = s_rddata;
                if (!m1_strobe || !s_wait) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level owner/priority model. Honors SRAM_ARB_ROUND_ROBIN_EN.
module tb_sram_arbiter;
    import aq32_bus_pkg::*;

    localparam int unsigned AW = SRAM_ADDR_W;
    localparam int unsigned SL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [31:0]   m0_wrdata, m1_wrdata, s_wrdata;
    logic [3:0]    m0_bytesel, m1_bytesel, s_bytesel;
    logic          m0_wren, m1_wren, s_wren;
    logic          m0_strobe, m1_strobe, s_strobe;
    logic          m0_wait, m1_wait, s_wait;
    logic [31:0]   m0_rddata, m1_rddata, s_rddata;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wrdata(m0_wrdata), .m0_bytesel(m0_bytesel), .m0_wren(m0_wren),
        .m0_strobe(m0_strobe), .m0_wait(m0_wait), .m0_rddata(m0_rddata),
        .m1_addr(m1_addr), .m1_wrdata(m1_wrdata), .m1_bytesel(m1_bytesel), .m1_wren(m1_wren),
        .m1_strobe(m1_strobe), .m1_wait(m1_wait), .m1_rddata(m1_rddata),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_bytesel(s_bytesel), .s_wren(s_wren),
        .s_strobe(s_strobe), .s_wait(s_wait), .s_rddata(s_rddata),
        .grant(grant)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the port (0 none, 1 m0, 2 m1), how long m1 has waited,
    // and which master finished last.
    int owner   = 0;
    int waited  = 0;
    int last    = 1;
    bit done0   = 1'b0;
    bit done1   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cyc();
        int  nxt;
        bit  s0, s1, m1_wins;
        @(negedge clk);
        s0 = m0_strobe;
        s1 = m1_strobe;
        chk("grant", 32'(grant), (owner == 1) ? 32'd1 : (owner == 2) ? 32'd2 : 32'd0);
        chk("s_strobe", 32'(s_strobe), (owner == 1) ? 32'(s0) : (owner == 2) ? 32'(s1) : 32'd0);
        if (owner == 1) begin
            chk("s_addr0", 32'(s_addr), 32'(m0_addr));
            chk("s_wrdata0", s_wrdata, m0_wrdata);
            chk("s_bytesel0", 32'(s_bytesel), 32'(m0_bytesel));
            chk("s_wren0", 32'(s_wren), 32'(m0_wren));
        end else if (owner == 2) begin
            chk("s_addr1", 32'(s_addr), 32'(m1_addr));
            chk("s_wrdata1", s_wrdata, m1_wrdata);
            chk("s_bytesel1", 32'(s_bytesel), 32'(m1_bytesel));
            chk("s_wren1", 32'(s_wren), 32'(m1_wren));
        end
        chk("m0_wait", 32'(m0_wait), (owner == 1) ? 32'(s_wait) : 32'd1);
        chk("m1_wait", 32'(m1_wait), (owner == 2) ? 32'(s_wait) : 32'd1);
        chk("m0_rddata", m0_rddata, (owner == 1) ? s_rddata : 32'd0);
        chk("m1_rddata", m1_rddata, (owner == 2) ? s_rddata : 32'd0);
        done0 = (owner == 1) && s0 && !s_wait;
        done1 = (owner == 2) && s1 && !s_wait;

        if (reset) begin
            nxt    = 0;
            waited = 0;
            last   = 1;
        end else begin
            nxt = owner;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            m1_wins = s1 && (!s0 || last == 0);
`else
            m1_wins = s1 && (!s0 || waited >= int'(SL));
`endif
            if (owner == 0) nxt = m1_wins ? 2 : (s0 ? 1 : 0);
            else if (owner == 1 && (!s0 || !s_wait)) nxt = 0;
            else if (owner == 2 && (!s1 || !s_wait)) nxt = 0;
            if (done0) last = 0;
            if (done1) last = 1;
            if (!s1 || nxt == 2) waited = 0;
            else if (owner != 2) waited = (waited < 255) ? waited + 1 : 255;
        end
        @(posedge clk);
        #1;
        owner = nxt;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        {m0_addr, m1_addr} = '0;
        {m0_wrdata, m1_wrdata} = '0;
        {m0_bytesel, m1_bytesel} = '0;
        {m0_wren, m1_wren, m0_strobe, m1_strobe} = '0;
        s_wait   = 1'b1;
        s_rddata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        chk("rst_grant", 32'(grant), 32'd0);
        reset = 1'b0;

        // Single m0 read at 0x00010.
        m0_addr = AW'(17'h00010); m0_wren = 1'b0; m0_bytesel = 4'hF; m0_strobe = 1'b1;
        cyc();
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_s_strobe", 32'(s_strobe), 32'd1);
        cyc();
        s_wait = 1'b0; s_rddata = 32'hDEADBEEF;
        #1;
        chk("t1_m0_wait", 32'(m0_wait), 32'd0);
        chk("t1_m0_rddata", m0_rddata, 32'hDEADBEEF);
        cyc();
        m0_strobe = 1'b0; s_wait = 1'b1;
        chk("t1_idle", 32'(grant), 32'd0);
        cyc();

        // Simultaneous requests.
        m0_strobe = 1'b1; m1_strobe = 1'b1; m1_addr = AW'(17'h1F000); m1_wren = 1'b0;
        cyc();
`ifndef SRAM_ARB_ROUND_ROBIN_EN
        chk("t2_m0_first", 32'(grant), 32'd1);
        chk("t2_m1_wait", 32'(m1_wait), 32'd1);
        cyc();
        s_wait = 1'b0;
        cyc();
        m0_strobe = 1'b0; s_wait = 1'b1;
        cyc();
        chk("t2_m1_next", 32'(grant), 32'd2);
`else
        cyc();
`endif
        s_wait = 1'b0;
        cyc();
        m0_strobe = 1'b0; m1_strobe = 1'b0; s_wait = 1'b1;
        cyc();

`ifndef SRAM_ARB_ROUND_ROBIN_EN
        // Continuous m0 traffic must not starve m1.
        m0_strobe = 1'b1; m1_strobe = 1'b1; m1_addr = AW'(17'h0ABCD); s_wait = 1'b0;
        n = 0;
        while (grant != 2'b10 && n < 20) begin
            cyc();
            n++;
        end
        chk("t3_grant", 32'(grant), 32'd2);
        chk("t3_cycles", 32'(n), 32'd5);
        chk("t3_s_addr", 32'(s_addr), 32'h0ABCD);
        cyc();
        m0_strobe = 1'b0; m1_strobe = 1'b0; s_wait = 1'b1;
        cyc();
`endif

        // m1 write pass-through.
        m1_strobe = 1'b1; m1_wren = 1'b1; m1_bytesel = 4'b0101; m1_wrdata = 32'h11223344;
        cyc();
        chk("t4_grant", 32'(grant), 32'd2);
        chk("t4_s_wren", 32'(s_wren), 32'd1);
        chk("t4_s_bytesel", 32'(s_bytesel), 32'h5);
        chk("t4_s_wrdata", s_wrdata, 32'h11223344);
        s_wait = 1'b0;
        cyc();
        m1_strobe = 1'b0; s_wait = 1'b1;
        cyc();

        // m0 aborts while waiting; m1 gets the port afterwards.
        m0_strobe = 1'b1; m1_strobe = 1'b1; m1_wren = 1'b0;
        cyc();
        chk("t5_grant0", 32'(grant), 32'd1);
        cyc();
        m0_strobe = 1'b0;
        #1;
        chk("t5_s_strobe", 32'(s_strobe), 32'd0);
        cyc();
        chk("t5_idle", 32'(grant), 32'd0);
        cyc();
        chk("t5_grant1", 32'(grant), 32'd2);
        cyc();

        // Reset while m1 owns the port.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_s_strobe", 32'(s_strobe), 32'd0);
        chk("t6_m0_wait", 32'(m0_wait), 32'd1);
        chk("t6_m1_wait", 32'(m1_wait), 32'd1);
        m1_strobe = 1'b0;
        cyc();

`ifdef SRAM_ARB_ROUND_ROBIN_EN
        // Alternating winners on back-to-back ties, starting with m0.
        m0_strobe = 1'b1; m1_strobe = 1'b1; s_wait = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rr_grant", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
            cyc();
        end
        m0_strobe = 1'b0; m1_strobe = 1'b0; s_wait = 1'b1;
        cyc();
`endif

        // Random traffic with aborts and occasional resets.
        done0 = 1'b0; done1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done0 || (m0_strobe && $urandom_range(0, 19) == 0)) begin
                m0_strobe = 1'b0;
            end else if (!m0_strobe && $urandom_range(0, 2) == 0) begin
                m0_strobe = 1'b1; m0_addr = AW'($urandom); m0_wrdata = $urandom;
                m0_bytesel = 4'($urandom); m0_wren = 1'($urandom);
            end
            if (done1 || (m1_strobe && $urandom_range(0, 19) == 0)) begin
                m1_strobe = 1'b0;
            end else if (!m1_strobe && $urandom_range(0, 2) == 0) begin
                m1_strobe = 1'b1; m1_addr = AW'($urandom); m1_wrdata = $urandom;
                m1_bytesel = 4'($urandom); m1_wren = 1'($urandom);
            end
            s_wait   = 1'($urandom_range(0, 1));
            s_rddata = $urandom;
            reset    = ($urandom_range(0, 99) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single sram_ctrl command port between two word-addressed bus masters: m0 (CPU) and m1 (DMA/ESP SPI master).
- Sits between the CPU bus interconnect and sram_ctrl, and uses the same strobe/wait/rddata handshake on every side.
- The grant is registered. m0 has fixed priority, and a starvation counter guarantees m1 a slot.

Parameters:
- ADDR_W, 17, word address width (address bits [18:2]).
- STARVE_LIMIT, 8, cycles m1 may wait in IDLE-lost arbitration before it is forced to win; range 1..255.

Ports:
- clk  in  1  system clock (28.63636MHz).
- reset  in  1  synchronous, active-high reset.
- m0_addr  in  ADDR_W  m0 word address.
- m0_wrdata  in  32  m0 write data.
- m0_bytesel  in  4  m0 byte enables.
- m0_wren  in  1  m0 write (1) / read (0).
- m0_strobe  in  1  m0 request.
- m0_wait  out  1  m0 stall; low in the completion cycle.
- m0_rddata  out  32  m0 read data, valid when m0_strobe && !m0_wait.
- m1_addr, m1_wrdata, m1_bytesel, m1_wren, m1_strobe, m1_wait, m1_rddata: same as the m0 set, for m1.
- s_addr  out  ADDR_W  to sram_ctrl bus_addr.
- s_wrdata  out  32  to sram_ctrl.
- s_bytesel  out  4  to sram_ctrl.
- s_wren  out  1  to sram_ctrl.
- s_strobe  out  1  to sram_ctrl.
- s_wait  in  1  from sram_ctrl.
- s_rddata  in  32  from sram_ctrl.
- grant  out  2  one-hot current owner; 00 in IDLE.

Behaviour:
- Master protocol:
  - A request is strobe=1 with addr, wrdata, bytesel and wren held stable until the cycle where wait=0.
  - wait=0 with strobe=1 completes the transfer.
- States: IDLE, GNT0, GNT1 (registered). Reset sets IDLE and starve_cnt=0.
- Reset output values: grant=00, s_strobe=0, m0_wait=1, m1_wait=1, rddata outputs 0.
- IDLE:
  - s_strobe=0; both m*_wait=1 while their strobe is high.
  - Next state is GNT1 if m1_strobe && (!m0_strobe || starve_cnt>=STARVE_LIMIT).
  - Otherwise GNT0 if m0_strobe; otherwise stay in IDLE.
- GNTx:
  - s_* = mx_* combinationally, with s_strobe=mx_strobe.
  - mx_wait = s_wait; mx_rddata = s_rddata. The other master sees wait=1 and rddata=0.
- Completion: in GNTx, when mx_strobe && !s_wait, the next state is IDLE. There is no back-to-back grant, so each transfer costs one arbitration cycle plus the sram_ctrl latency.
- Abort: if mx_strobe drops while in GNTx, s_strobe drops the same cycle and the next state is IDLE.
- starve_cnt (8-bit, saturating):
  - Increments each cycle m1_strobe=1 and state!=GNT1.
  - Clears when GNT1 is entered or m1_strobe=0.
  - Saturates at 255 and never wraps.
- Simultaneous requests in IDLE with starve_cnt<STARVE_LIMIT: m0 wins.
- Reset mid-transfer: state returns to IDLE in the next cycle and s_strobe=0. sram_ctrl is reset by the same signal.
- Writes complete on s_wait=0 exactly like reads; the arbiter adds no buffering of data.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner register (reset 1) replaces fixed priority.
  - On simultaneous requests in IDLE the master that was not last_owner wins.
  - last_owner updates on each completion.
  - starve_cnt and STARVE_LIMIT are unused; the parameter is accepted but ignored.
- Undefined: fixed m0 priority with the starvation counter, as above.

Decomposition:
- Package aq32_bus_pkg holds:
  - state encodings ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2;
  - constant SRAM_ADDR_W=17;
  - constant BUS_DATA_W=32.
- Single module. Starvation counter and mux are inline; no sub-module is warranted.

Test Plan:
- Single m0 read, addr 0x00010:
  - s_strobe asserts 1 cycle after m0_strobe; grant=01.
  - m0_wait falls on the cycle s_wait falls; m0_rddata equals s_rddata (0xDEADBEEF).
  - Back in IDLE the next cycle.
- Simultaneous m0/m1 requests with STARVE_LIMIT=8:
  - m0 is granted first.
  - m1 is granted immediately after m0 completes.
  - m1_wait stays 1 throughout the m0 transfer.
- Continuous m0 strobe plus m1 strobe, STARVE_LIMIT=3:
  - m1 wins once starve_cnt reaches 3 at an IDLE decision.
  - grant=10 and s_addr=m1_addr.
- m1 write, bytesel=4'b0101, wrdata=0x11223344: s_wren=1, s_bytesel=0101 and s_wrdata pass through unchanged while grant=10.
- Abort: m0_strobe drops while s_wait=1 in GNT0 → s_strobe=0 the same cycle, IDLE next cycle, m1 serviced afterwards.
- Reset asserted during GNT1 → the next cycle has grant=00, s_strobe=0 and both waits=1.
- With SRAM_ARB_ROUND_ROBIN_EN: four back-to-back simultaneous requests produce grants m0, m1, m0, m1 (last_owner reset=1).
